// File: rtl/ibex_branch_resolve.sv
// Tracks fetch-stage branch predictions in order and checks each one against the
// execute-stage outcome, issuing a registered redirect on a mispredict.
module ibex_branch_resolve #(
  parameter int unsigned DEPTH = 2
) (
  input  logic        clk_i,
  input  logic        rst_i,
  input  logic        pred_valid_i,
  output logic        pred_ready_o,
  input  logic [31:0] pred_pc_i,
  input  logic        pred_taken_i,
  input  logic [31:0] pred_target_i,
  input  logic        pred_compressed_i,
  input  logic        res_valid_i,
  input  logic        res_taken_i,
  input  logic [31:0] res_target_i,
  input  logic        flush_i,
  output logic        mispredict_o,
  output logic [31:0] redirect_pc_o,
  output logic        underflow_o,
  output logic [31:0] resolved_cnt_o,
  output logic [31:0] mispredict_cnt_o
);

  localparam int unsigned PTR_W   = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int unsigned CNT_W   = PTR_W + 1;
  localparam logic [31:0] CNT_MAX = 32'hFFFF_FFFF;

  logic [31:0]      pc_q     [DEPTH];
  logic [31:0]      target_q [DEPTH];
  logic [DEPTH-1:0] taken_q;
  logic [DEPTH-1:0] comp_q;

  logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
  logic [CNT_W-1:0] count_q, count_d;
  logic             mispredict_q, mispredict_d;
  logic             underflow_q, underflow_d;
  logic [31:0]      redirect_q, redirect_d;
  logic [31:0]      resolved_cnt_q;
  logic [31:0]      mispredict_cnt_q;

  logic        push_c, pop_c, wr_en_c, wrong_c, count_res_c;
  logic [31:0] head_pc_c, head_target_c, fallthrough_c;
  logic        head_taken_c, head_comp_c;

  assign pred_ready_o = (count_q != CNT_W'(DEPTH));

  // Head compare, pointer/occupancy next state and registered pulse outputs
  always_comb begin
    head_pc_c     = pc_q[rd_ptr_q];
    head_target_c = target_q[rd_ptr_q];
    head_taken_c  = taken_q[rd_ptr_q];
    head_comp_c   = comp_q[rd_ptr_q];
    fallthrough_c = head_pc_c + (head_comp_c ? 32'd2 : 32'd4);

    push_c  = pred_valid_i & pred_ready_o;
    pop_c   = res_valid_i & (count_q != '0);
    wrong_c = pop_c & ((head_taken_c != res_taken_i) |
                       (head_taken_c & res_taken_i & (head_target_c != res_target_i)));
    count_res_c = pop_c & ~flush_i & (head_taken_c | res_taken_i);
    wr_en_c     = push_c & ~flush_i & ~wrong_c;

    wr_ptr_d     = wr_ptr_q;
    rd_ptr_d     = rd_ptr_q;
    count_d      = count_q;
    mispredict_d = 1'b0;
    underflow_d  = 1'b0;
    redirect_d   = redirect_q;

    if (flush_i) begin
      wr_ptr_d = '0;
      rd_ptr_d = '0;
      count_d  = '0;
    end else if (wrong_c) begin
      // Everything younger than the head is wrong-path, including a same-cycle push
      wr_ptr_d     = '0;
      rd_ptr_d     = '0;
      count_d      = '0;
      mispredict_d = 1'b1;
      redirect_d   = res_taken_i ? res_target_i : fallthrough_c;
    end else begin
      underflow_d = res_valid_i & (count_q == '0);
      if (push_c) wr_ptr_d = wr_ptr_q + PTR_W'(1);
      if (pop_c)  rd_ptr_d = rd_ptr_q + PTR_W'(1);
      if (push_c && !pop_c)      count_d = count_q + CNT_W'(1);
      else if (!push_c && pop_c) count_d = count_q - CNT_W'(1);
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      wr_ptr_q         <= '0;
      rd_ptr_q         <= '0;
      count_q          <= '0;
      mispredict_q     <= 1'b0;
      underflow_q      <= 1'b0;
      redirect_q       <= '0;
      resolved_cnt_q   <= '0;
      mispredict_cnt_q <= '0;
    end else begin
      wr_ptr_q     <= wr_ptr_d;
      rd_ptr_q     <= rd_ptr_d;
      count_q      <= count_d;
      mispredict_q <= mispredict_d;
      underflow_q  <= underflow_d;
      redirect_q   <= redirect_d;
      if (count_res_c && resolved_cnt_q != CNT_MAX)
        resolved_cnt_q <= resolved_cnt_q + 32'd1;
      if (mispredict_d && mispredict_cnt_q != CNT_MAX)
        mispredict_cnt_q <= mispredict_cnt_q + 32'd1;
    end
  end

  // Payload storage needs no reset; occupancy alone decides what is live
  always_ff @(posedge clk_i) begin
    if (wr_en_c) begin
      pc_q[wr_ptr_q]     <= pred_pc_i;
      target_q[wr_ptr_q] <= pred_target_i;
      taken_q[wr_ptr_q]  <= pred_taken_i;
      comp_q[wr_ptr_q]   <= pred_compressed_i;
    end
  end

  assign mispredict_o     = mispredict_q;
  assign underflow_o      = underflow_q;
  assign redirect_pc_o    = redirect_q;
  assign resolved_cnt_o   = resolved_cnt_q;
  assign mispredict_cnt_o = mispredict_cnt_q;

endmodule

// File: tb/tb_ibex_branch_resolve.sv
// Directed and randomized bench for ibex_branch_resolve against a queue-based
// reference model of prediction tracking and resolution.
module tb_ibex_branch_resolve;

  localparam int unsigned DEPTH = 2;

  logic        clk = 1'b0;
  logic        rst;
  logic        pred_valid, pred_ready;
  logic [31:0] pred_pc, pred_target;
  logic        pred_taken, pred_comp;
  logic        res_valid, res_taken;
  logic [31:0] res_target;
  logic        flush;
  logic        mispredict, underflow;
  logic [31:0] redirect_pc, resolved_cnt, mispredict_cnt;

  always #5 clk = ~clk;

  ibex_branch_resolve #(.DEPTH(DEPTH)) dut (
    .clk_i            (clk),
    .rst_i            (rst),
    .pred_valid_i     (pred_valid),
    .pred_ready_o     (pred_ready),
    .pred_pc_i        (pred_pc),
    .pred_taken_i     (pred_taken),
    .pred_target_i    (pred_target),
    .pred_compressed_i(pred_comp),
    .res_valid_i      (res_valid),
    .res_taken_i      (res_taken),
    .res_target_i     (res_target),
    .flush_i          (flush),
    .mispredict_o     (mispredict),
    .redirect_pc_o    (redirect_pc),
    .underflow_o      (underflow),
    .resolved_cnt_o   (resolved_cnt),
    .mispredict_cnt_o (mispredict_cnt)
  );

  typedef struct {
    logic [31:0] pc;
    logic        taken;
    logic [31:0] target;
    logic        comp;
  } rec_t;

  rec_t        mq[$];
  logic        m_mis, m_und;
  logic [31:0] m_redir, m_res_cnt, m_mis_cnt;
  int          n_tests = 0;
  int          n_fail  = 0;

  task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", tag, act, exp);
    end
  endtask

  function automatic logic [31:0] sat_inc(input logic [31:0] x);
    return (x == 32'hFFFF_FFFF) ? x : x + 32'd1;
  endfunction

  task automatic clear_inputs();
    rst = 1'b0; flush = 1'b0; pred_valid = 1'b0; res_valid = 1'b0;
  endtask

  task automatic offer(input logic [31:0] pc, input logic tk, input logic [31:0] tgt, input logic c);
    pred_valid = 1'b1; pred_pc = pc; pred_taken = tk; pred_target = tgt; pred_comp = c;
  endtask

  task automatic resolve(input logic tk, input logic [31:0] tgt);
    res_valid = 1'b1; res_taken = tk; res_target = tgt;
  endtask

  // One clock: advance the model with the inputs seen at the edge, then compare every output
  task automatic step();
    bit          rdy, wrong;
    rec_t        h, r;
    logic [31:0] ft;
    rdy   = (mq.size() < DEPTH);
    wrong = 1'b0;
    @(posedge clk);
    if (rst) begin
      mq.delete();
      m_mis = 0; m_und = 0; m_redir = '0; m_res_cnt = '0; m_mis_cnt = '0;
    end else if (flush) begin
      mq.delete();
      m_mis = 0; m_und = 0;
    end else begin
      m_mis = 0; m_und = 0;
      if (res_valid && mq.size() == 0) begin
        m_und = 1;
      end else if (res_valid) begin
        h  = mq.pop_front();
        ft = h.pc + (h.comp ? 32'd2 : 32'd4);
        wrong = (h.taken != res_taken) || (h.taken && res_taken && h.target != res_target);
        if (h.taken || res_taken) m_res_cnt = sat_inc(m_res_cnt);
        if (wrong) begin
          m_mis     = 1;
          m_redir   = res_taken ? res_target : ft;
          m_mis_cnt = sat_inc(m_mis_cnt);
          mq.delete();
        end
      end
      if (pred_valid && rdy && !wrong) begin
        r.pc = pred_pc; r.taken = pred_taken; r.target = pred_target; r.comp = pred_comp;
        mq.push_back(r);
      end
    end
    #1;
    check("mispredict",     32'(mispredict),  32'(m_mis));
    check("underflow",      32'(underflow),   32'(m_und));
    check("redirect_pc",    redirect_pc,      m_redir);
    check("resolved_cnt",   resolved_cnt,     m_res_cnt);
    check("mispredict_cnt", mispredict_cnt,   m_mis_cnt);
    check("pred_ready",     32'(pred_ready),  32'(mq.size() < DEPTH));
    clear_inputs();
  endtask

  initial begin
    pred_pc = '0; pred_taken = 0; pred_target = '0; pred_comp = 0;
    res_taken = 0; res_target = '0;
    clear_inputs();
    m_mis = 0; m_und = 0; m_redir = '0; m_res_cnt = '0; m_mis_cnt = '0;

    rst = 1'b1; step();
    check("reset_redirect", redirect_pc, 32'h0);
    check("reset_ready",    32'(pred_ready), 32'd1);

    // Correct not-taken
    offer(32'h100, 0, 32'h0, 0); step();
    resolve(0, 32'h0); step();
    check("nt_no_mis", 32'(mispredict), 32'd0);
    check("nt_res_cnt", resolved_cnt, 32'd0);

    // Backward branch predicted taken, actually not taken
    offer(32'h200, 1, 32'h1F0, 1); step();
    resolve(0, 32'h0); step();
    check("bwd_mis",   32'(mispredict), 32'd1);
    check("bwd_redir", redirect_pc, 32'h202);
    check("bwd_cnt",   mispredict_cnt, 32'd1);
    step();
    check("bwd_pulse_end", 32'(mispredict), 32'd0);
    check("bwd_redir_hold", redirect_pc, 32'h202);

    // Target mismatch discards younger entries and a same-cycle offer
    offer(32'h300, 1, 32'h400, 0); step();
    offer(32'h304, 0, 32'h0, 0);   step();
    check("full_ready", 32'(pred_ready), 32'd0);
    offer(32'h308, 0, 32'h0, 0); resolve(1, 32'h500); step();
    check("tgt_redir", redirect_pc, 32'h500);
    check("tgt_ready", 32'(pred_ready), 32'd1);
    resolve(0, 32'h0); step();
    check("tgt_empty_underflow", 32'(underflow), 32'd1);

    // Back-pressure, wrap and 32-bit fallthrough wrap
    offer(32'h1000, 0, 32'h0, 0); step();
    offer(32'h1004, 0, 32'h0, 1); step();
    offer(32'h1006, 0, 32'h0, 0); step();
    check("bp_ready", 32'(pred_ready), 32'd0);
    resolve(0, 32'h0); step();
    check("bp_ready_after_pop", 32'(pred_ready), 32'd1);
    for (int i = 0; i < 5; i++) begin
      offer(32'h2000 + 32'(4 * i), 0, 32'h0, 0); resolve(0, 32'h0); step();
    end
    resolve(0, 32'h0); step();
    resolve(0, 32'h0); step();
    check("wrap_drained_ready", 32'(pred_ready), 32'd1);
    offer(32'hFFFF_FFFE, 1, 32'h40, 1); step();
    resolve(0, 32'h0); step();
    check("ft_wrap_redir", redirect_pc, 32'h0);

    // Flush beats a mispredicting resolve
    offer(32'h500, 1, 32'h600, 0); step();
    resolve(0, 32'h0); flush = 1'b1; step();
    check("flush_no_mis", 32'(mispredict), 32'd0);
    resolve(0, 32'h0); step();
    check("flush_emptied", 32'(underflow), 32'd1);

    // Reset mid-stream
    offer(32'h700, 1, 32'h800, 0); step();
    rst = 1'b1; offer(32'h704, 0, 32'h0, 0); step();
    check("rst_mis_cnt", mispredict_cnt, 32'h0);
    check("rst_res_cnt", resolved_cnt,   32'h0);

    // Saturation of both counters
    @(negedge clk);
    dut.mispredict_cnt_q = 32'hFFFF_FFFF; m_mis_cnt = 32'hFFFF_FFFF;
    dut.resolved_cnt_q   = 32'hFFFF_FFFF; m_res_cnt = 32'hFFFF_FFFF;
    offer(32'h900, 1, 32'hA00, 0); step();
    resolve(1, 32'hB00); step();
    check("sat_mis_cnt", mispredict_cnt, 32'hFFFF_FFFF);
    check("sat_res_cnt", resolved_cnt,   32'hFFFF_FFFF);

    rst = 1'b1; step();

    // Randomized traffic with a small target pool so predictions often match
    for (int i = 0; i < 600; i++) begin
      pred_valid  = ($urandom_range(0, 9) < 6);
      pred_pc     = $urandom() & 32'hFFFF_FFFE;
      pred_taken  = 1'($urandom_range(0, 1));
      pred_target = $urandom_range(0, 1) ? 32'h1000 : 32'h2000;
      pred_comp   = 1'($urandom_range(0, 1));
      res_valid   = ($urandom_range(0, 9) < 5);
      res_taken   = 1'($urandom_range(0, 1));
      res_target  = $urandom_range(0, 1) ? 32'h1000 : 32'h2000;
      flush       = ($urandom_range(0, 39) == 0);
      rst         = ($urandom_range(0, 99) == 0);
      step();
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
